// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract controller.
package nibble_serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nib_cnt_w(input int width);
        return (width / 4 <= 2) ? 1 : $clog2(width / 4);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_slice.sv
// One 4-bit add/subtract slice; cin is separate from m so nibbles chain.
module addsub_nibble_slice
    import nibble_serial_addsub_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c3,
    output logic       c4
);

    logic [3:0] w_bx;
    logic [4:0] w_full;

    assign w_bx   = b ^ {4{m}};
    assign w_full = {1'b0, a} + {1'b0, w_bx} + {4'b0, cin};
    assign sum    = w_full[3:0];
    assign c4     = w_full[4];
    // carry into bit 3 recovered from the bit-3 sum
    assign c3     = a[3] ^ w_bx[3] ^ w_full[3];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Sequences one 4-bit slice over WIDTH/4 cycles, LSB nibble first.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);

    localparam int NIB       = WIDTH / 4;
    localparam int NIB_CNT_W = nib_cnt_w(WIDTH);
    localparam logic [NIB_CNT_W-1:0] LAST = NIB_CNT_W'(NIB - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-5:0]     r_acc;
    logic [WIDTH-1:0]     r_s;
    logic [NIB_CNT_W-1:0] r_cnt;
    logic                 r_m;
    logic                 r_cy;
    logic                 r_c;
    logic                 r_v;
    logic                 r_z;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic [3:0]           w_sum;
    logic                 w_c3;
    logic                 w_c4;
    logic [WIDTH-1:0]     w_final;

    addsub_nibble_slice u_slice (
        .a   (r_a[3:0]),
        .b   (r_b[3:0]),
        .m   (r_m),
        .cin (r_cy),
        .sum (w_sum),
        .c3  (w_c3),
        .c4  (w_c4)
    );

    // sum nibbles enter from the MSB side
    assign w_final = {w_sum, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_m     <= 1'b0;
            r_cy    <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_m     <= M;
                        r_cy    <= M;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 4;
                    r_b   <= r_b >> 4;
                    r_acc <= w_final[WIDTH-1:4];
                    r_cy  <= w_c4;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_s     <= w_final;
                        r_c     <= w_c4;
                        r_v     <= w_c3 ^ w_c4;
                        r_z     <= (w_final == '0);
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign S     = r_s;
    assign C     = r_c;
    assign V     = r_v;
    assign Z     = r_z;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Random plus directed bench for nibble_serial_addsub_ctrl against an arithmetic model.
module tb_nibble_serial_addsub_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         M = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         ready, busy, done, C, V, Z;
    logic [W-1:0] S;

    int checks = 0;
    int failures = 0;
    bit en = 1'b0;

    nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .M(M), .A(A), .B(B),
        .ready(ready), .busy(busy), .done(done),
        .S(S), .C(C), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // result of one whole-word operation: {C, V, Z, S}
    function automatic logic [W+2:0] calc(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic m);
        logic [W:0]   ext;
        logic [W-1:0] bo;
        logic         v;
        bo  = m ? ~b : b;
        ext = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, m};
        if (!m) v = (a[W-1] == b[W-1]) && (ext[W-1] != a[W-1]);
        else    v = (a[W-1] != b[W-1]) && (ext[W-1] != a[W-1]);
        return {ext[W], v, (ext[W-1:0] == '0), ext[W-1:0]};
    endfunction

    logic         m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    logic         m_c = 1'b0, m_v = 1'b0, m_z = 1'b0;
    logic [W-1:0] m_s = '0;
    logic [W+2:0] m_pend = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
            m_s <= '0; m_c <= 1'b0; m_v <= 1'b0; m_z <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_ready && start) begin
                m_pend  <= calc(A, B, M);
                m_left  <= NIB;
                m_ready <= 1'b0;
                m_busy  <= 1'b1;
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_c, m_v, m_z, m_s} <= m_pend;
                    m_done  <= 1'b1;
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("ready", {31'b0, ready}, {31'b0, m_ready});
            chk("busy",  {31'b0, busy},  {31'b0, m_busy});
            chk("done",  {31'b0, done},  {31'b0, m_done});
            chk("S", {16'b0, S}, {16'b0, m_s});
            chk("C", {31'b0, C}, {31'b0, m_c});
            chk("V", {31'b0, V}, {31'b0, m_v});
            chk("Z", {31'b0, Z}, {31'b0, m_z});
        end
    end

    // one op; done must pulse exactly once, in the 5th cycle after accept
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic m, input logic [W-1:0] es,
                      input logic ec, input logic ev, input logic ez,
                      input int glitch_at);
        int n, got;
        @(posedge clk); #1;
        A = a; B = b; M = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); M = 1'($urandom);
        n = 0; got = -1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == glitch_at) begin
                start = 1'b1; A = 16'hAAAA; B = 16'h5555; M = ~m;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n++;
                if (got < 0) got = i;
                chk("lit_S", {16'b0, S}, {16'b0, es});
                chk("lit_CVZ", {29'b0, C, V, Z}, {29'b0, ec, ev, ez});
            end
        end
        chk("done_latency", got, NIB + 1);
        chk("done_count", n, 1);
    endtask

    initial begin : main
        int n, got;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_SCVZ",  {13'b0, S, C, V, Z}, 32'd0);
        en = 1'b1;

        op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0);
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
        op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 2);

        // back-to-back start on the done cycle
        @(posedge clk); #1;
        A = 16'h4321; B = 16'h0021; M = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                n++;
                if (got < 0) begin
                    got = i;
                    A = 16'd3; B = 16'd4; M = 1'b0; start = 1'b1;
                end
            end
            if (i == 5) chk("b2b_first_S", {16'b0, S}, 32'h4300);
            if (i > 5 && i < 10) chk("b2b_hold_S", {16'b0, S}, 32'h4300);
            if (i == 10) begin
                chk("b2b_second_done", {31'b0, done}, 32'd1);
                chk("b2b_second_S", {16'b0, S}, 32'h0007);
            end
        end
        chk("b2b_first_latency", got, 5);
        chk("b2b_done_count", n, 2);

        // reset in the middle of RUN
        @(posedge clk); #1;
        A = 16'h00FF; B = 16'h0001; M = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            rst = (i == 3);
            if (done) n++;
            if (i == 4) begin
                chk("abort_ready", {31'b0, ready}, 32'd1);
                chk("abort_busy",  {31'b0, busy},  32'd0);
                chk("abort_SCVZ",  {13'b0, S, C, V, Z}, 32'd0);
            end
        end
        chk("abort_no_done", n, 0);
        op(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 0);

        // random traffic, including starts while busy and rare resets
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            A = W'($urandom); B = W'($urandom); M = 1'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) B = A;
        end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
